booth_feeder: RTL and testbench

BOOTH_FEEDER -- requirements
Module: booth_feeder

---
 rtl/booth_pkg.sv | 17 +
 rtl/booth_operand_fifo.sv | 66 ++++++
 rtl/booth_feeder.sv | 191 +++++++++++++++++++
 tb/tb_booth_feeder.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared defaults and FSM state encoding for the Booth multiplier operand feeder.
package booth_pkg;

  localparam int BOOTH_N_DEFAULT       = 8;
  localparam int BOOTH_DEPTH_DEFAULT   = 2;
  localparam int BOOTH_TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_LOAD_M = 3'd2,
    ST_LOAD_Q = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESP   = 3'd5
  } feeder_state_e;

endpackage

// File: rtl/booth_operand_fifo.sv
// Small power-of-two operand-pair queue; push is ignored when full, pop when empty.
module booth_operand_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Storage array: contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1'b1);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1'b1);
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1'b1);
        2'b01:   count_q <= count_q - CW'(1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/booth_feeder.sv
// Queues operand pairs and sequences them onto a shared-bus Booth multiplier core.
// Optional WAIT-state abort is built only when BOOTH_FEEDER_TIMEOUT_EN is defined.
module booth_feeder
  import booth_pkg::*;
#(
  parameter int N              = BOOTH_N_DEFAULT,
  parameter int DEPTH          = BOOTH_DEPTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = BOOTH_TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_m,
  input  logic [N-1:0]   in_q,
  output logic           core_start,
  output logic [N-1:0]   core_data,
  input  logic           core_done,
  input  logic [2*N-1:0] core_ans,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_ans,
  output logic           out_err,
  output logic           busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  feeder_state_e  state_q, state_d;
  logic [N-1:0]   m_q, m_d;
  logic [N-1:0]   q_q, q_d;
  logic [2*N-1:0] out_ans_q, out_ans_d;
  logic           out_valid_q, out_valid_d;
  logic           core_start_q, core_start_d;
  logic [N-1:0]   core_data_q, core_data_d;
  logic           busy_q, busy_d;

  logic           push_s;
  logic           pop_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [2*N-1:0] fifo_head_s;
  logic [CW-1:0]  fifo_count_s;
  logic [CW-1:0]  count_next_s;

`ifdef BOOTH_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          out_err_q, out_err_d;
  logic          timeout_s;
  assign timeout_s = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign out_err   = out_err_q;
`else
  assign out_err   = 1'b0;
`endif

  assign in_ready     = !fifo_full_s;
  assign push_s       = in_valid && !fifo_full_s;
  assign count_next_s = fifo_count_s + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};

  booth_operand_fifo #(
    .W     (2*N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .data_i  ({in_m, in_q}),
    .pop_i   (pop_s),
    .head_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Sequencer next state; the head pair is captured into issue registers on pop.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    out_ans_d = out_ans_q;
    pop_s     = 1'b0;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
    out_err_d = out_err_q;
    tcnt_d    = tcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          m_d     = fifo_head_s[2*N-1:N];
          q_d     = fifo_head_s[N-1:0];
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START:  state_d = ST_LOAD_M;
      ST_LOAD_M: state_d = ST_LOAD_Q;
      ST_LOAD_Q: begin
        state_d = ST_WAIT;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
        tcnt_d  = {TW{1'b0}};
`endif
      end
      ST_WAIT: begin
        if (core_done) begin
          out_ans_d = core_ans;
          state_d   = ST_RESP;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
          out_err_d = 1'b0;
        end else if (timeout_s) begin
          out_ans_d = {(2*N){1'b0}};
          out_err_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          tcnt_d    = tcnt_q + TW'(1'b1);
          state_d   = ST_WAIT;
        end
`else
        end else begin
          state_d   = ST_WAIT;
        end
`endif
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the block registered.
  always_comb begin
    core_start_d = (state_d == ST_START);
    out_valid_d  = (state_d == ST_RESP);
    busy_d       = (state_d != ST_IDLE) || (count_next_s != {CW{1'b0}});
    case (state_d)
      ST_START, ST_LOAD_M: core_data_d = m_d;
      ST_LOAD_Q, ST_WAIT:  core_data_d = q_d;
      default:             core_data_d = {N{1'b0}};
    endcase
  end

  // State, issue and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      m_q          <= {N{1'b0}};
      q_q          <= {N{1'b0}};
      out_ans_q    <= {(2*N){1'b0}};
      out_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      core_data_q  <= {N{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      q_q          <= q_d;
      out_ans_q    <= out_ans_d;
      out_valid_q  <= out_valid_d;
      core_start_q <= core_start_d;
      core_data_q  <= core_data_d;
      busy_q       <= busy_d;
    end
  end

`ifdef BOOTH_FEEDER_TIMEOUT_EN
  // WAIT-state abort counter and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q    <= {TW{1'b0}};
      out_err_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      out_err_q <= out_err_d;
    end
  end
`endif

  assign core_start = core_start_q;
  assign core_data  = core_data_q;
  assign out_valid  = out_valid_q;
  assign out_ans    = out_ans_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_booth_feeder.sv
// Self-checking bench for booth_feeder: vector table, corner sequences, random traffic
// against a behavioural core model and an in-order result scoreboard.
module tb_booth_feeder;

  typedef struct {
    logic [7:0] m;
    logic [7:0] q;
  } pair_t;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] ans;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_m = 8'h00;
  logic [7:0]  in_q = 8'h00;
  logic        core_done = 1'b0;
  logic [15:0] core_ans = 16'h0000;
  logic        out_ready = 1'b0;
  logic        in_ready, core_start, out_valid, out_err, busy;
  logic [7:0]  core_data;
  logic [15:0] out_ans;

  int n_vec = 0;
  int n_err = 0;
  int n_res = 0;
  int n_push = 0;

  pair_t pushq[$];
  pair_t issq[$];
  pair_t cur;

  int   cm_ph = 0;
  int   cm_cnt = 0;
  int   cm_lat = 0;
  logic [7:0] cm_m, cm_q;
  int   fixed_lat = 0;
  bit   rand_lat = 1'b0;
  bit   hold = 1'b0;
  bit   exp_timeout = 1'b0;
  int   done_req = 0;
  int   done_ack = 0;

  bit          held = 1'b0;
  logic [15:0] held_ans;
  logic        held_err;

  vec_t tbl[8];

  booth_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_m       (in_m),
    .in_q       (in_q),
    .core_start (core_start),
    .core_data  (core_data),
    .core_done  (core_done),
    .core_ans   (core_ans),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ans    (out_ans),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int sa, sb, p;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    return p[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [7:0] m, input logic [7:0] q);
    int k;
    pair_t p;
    k = 0;
    in_valid = 1'b1;
    in_m = m;
    in_q = q;
    while (!in_ready && k < 200) begin
      step();
      k++;
    end
    chk("push_accept", in_ready, 1);
    if (in_ready) begin
      p.m = m;
      p.q = q;
      pushq.push_back(p);
      n_push++;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name, input int bound);
    int k;
    k = 0;
    while (!out_valid && k < bound) begin
      step();
      k++;
    end
    chk(name, out_valid, 1);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int k;
    k = 0;
    while ((pushq.size() != 0 || issq.size() != 0) && k < bound) begin
      step();
      k++;
    end
    chk(name, pushq.size() + issq.size(), 0);
  endtask

  // Behavioural multiplier core: latches M on start, Q two cycles later, answers after a latency.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (reset) begin
      cm_ph = 0;
    end else begin
      if (done_req != done_ack) begin
        core_done = 1'b1;
        core_ans  = 16'hA5A5;
        done_ack  = done_req;
      end
      case (cm_ph)
        0: begin
          if (core_start) begin
            chk("issue_expected", pushq.size() != 0, 1);
            if (pushq.size() != 0) begin
              cur = pushq.pop_front();
              issq.push_back(cur);
            end
            chk("start_data", core_data, cur.m);
            cm_m  = core_data;
            cm_ph = 1;
          end else begin
            chk("idle_data", core_data, 0);
          end
        end
        1: begin
          chk("start_pulse", core_start, 0);
          chk("loadm_data", core_data, cm_m);
          cm_ph = 2;
        end
        2: begin
          chk("start_pulse", core_start, 0);
          chk("loadq_data", core_data, cur.q);
          cm_q   = core_data;
          cm_ph  = 3;
          cm_cnt = 0;
          cm_lat = rand_lat ? int'($urandom_range(0, 4)) : fixed_lat;
        end
        default: begin
          if (out_valid) begin
            cm_ph = 0;
          end else begin
            chk("wait_data", core_data, cm_q);
            if (!hold && cm_cnt == cm_lat) begin
              core_done = 1'b1;
              core_ans  = ref_prod(cm_m, cm_q);
              cm_ph     = 0;
            end else begin
              cm_cnt++;
            end
          end
        end
      endcase
    end
  end

  // Result scoreboard: in-order products, stable outputs while stalled.
  always @(negedge clk) begin
    pair_t e;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held && out_valid) begin
        chk("hold_ans", out_ans, held_ans);
        chk("hold_err", out_err, held_err);
      end
      if (out_valid && out_ready) begin
        chk("result_expected", issq.size() != 0, 1);
        if (issq.size() != 0) begin
          e = issq.pop_front();
          if (exp_timeout) begin
            chk("res_ans", out_ans, 0);
            chk("res_err", out_err, 1);
          end else begin
            chk("res_ans", out_ans, ref_prod(e.m, e.q));
            chk("res_err", out_err, 0);
          end
        end
        n_res++;
        held = 1'b0;
      end else if (out_valid) begin
        held     = 1'b1;
        held_ans = out_ans;
        held_err = out_err;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    bit bad;
    tbl[0] = '{m: 8'h03, q: 8'h05, ans: 16'h000F};
    tbl[1] = '{m: 8'hFD, q: 8'h05, ans: 16'hFFF1};
    tbl[2] = '{m: 8'h80, q: 8'h80, ans: 16'h4000};
    tbl[3] = '{m: 8'h7F, q: 8'h7F, ans: 16'h3F01};
    tbl[4] = '{m: 8'hFF, q: 8'hFF, ans: 16'h0001};
    tbl[5] = '{m: 8'h00, q: 8'h55, ans: 16'h0000};
    tbl[6] = '{m: 8'h80, q: 8'h7F, ans: 16'hC080};
    tbl[7] = '{m: 8'h7F, q: 8'h80, ans: 16'hC080};

    // Reset values
    repeat (3) step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ans", out_ans, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    // Two-cycle issue latency and core_data sequence for a negative multiplicand
    push_pair(8'hFD, 8'h05);
    chk("lat_c1_start", core_start, 0);
    chk("lat_busy", busy, 1);
    step();
    chk("lat_c2_start", core_start, 1);
    chk("seq_start_data", core_data, 8'hFD);
    step();
    chk("seq_loadm_start", core_start, 0);
    chk("seq_loadm_data", core_data, 8'hFD);
    step();
    chk("seq_loadq_data", core_data, 8'h05);
    wait_out_valid("seq_valid", 40);
    chk("seq_ans", out_ans, 16'hFFF1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      fixed_lat = i % 3;
      push_pair(tbl[i].m, tbl[i].q);
      wait_out_valid("tbl_valid", 40);
      chk("tbl_ans", out_ans, tbl[i].ans);
      chk("tbl_err", out_err, 0);
      chk("tbl_busy", busy, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    step();

    // core_done while idle is ignored
    done_req++;
    bad = 1'b0;
    repeat (5) begin
      step();
      if (out_valid || busy || !in_ready || core_start) bad = 1'b1;
    end
    chk("idle_done_ignored", bad, 0);

    // Three back-to-back pairs with the consumer stalled
    fixed_lat = 3;
    base = n_res;
    push_pair(8'h11, 8'h02);
    push_pair(8'hF0, 8'h10);
    push_pair(8'h05, 8'hFB);
    chk("b2b_in_ready_low", in_ready, 0);
    wait_out_valid("b2b_valid", 40);
    chk("b2b_still_full", in_ready, 0);
    chk("b2b_busy", busy, 1);
    out_ready = 1'b1;
    wait_drain("b2b_drain", 200);
    step();
    out_ready = 1'b0;
    chk("b2b_count", n_res - base, 3);

`ifdef BOOTH_FEEDER_TIMEOUT_EN
    // Core never answers: abort after 64 WAIT cycles
    hold = 1'b1;
    exp_timeout = 1'b1;
    push_pair(8'h21, 8'h43);
    k = 0;
    while (!core_start && k < 20) begin
      step();
      k++;
    end
    chk("to_start", core_start, 1);
    bad = 1'b0;
    repeat (66) begin
      step();
      if (out_valid) bad = 1'b1;
    end
    chk("to_early", bad, 0);
    step();
    chk("to_valid", out_valid, 1);
    chk("to_err", out_err, 1);
    chk("to_ans", out_ans, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    exp_timeout = 1'b0;
    hold = 1'b0;
`endif

    // Reset during WAIT with one pair still queued
    hold = 1'b1;
    push_pair(8'h33, 8'h44);
    push_pair(8'h55, 8'h66);
    k = 0;
    while (cm_ph != 3 && k < 20) begin
      step();
      k++;
    end
    chk("rw_in_wait", cm_ph, 3);
    chk("rw_queued", in_ready, 1);
    reset = 1'b1;
    step();
    chk("rw_in_ready", in_ready, 1);
    chk("rw_core_start", core_start, 0);
    chk("rw_core_data", core_data, 0);
    chk("rw_out_valid", out_valid, 0);
    chk("rw_out_ans", out_ans, 0);
    chk("rw_out_err", out_err, 0);
    chk("rw_busy", busy, 0);
    reset = 1'b0;
    pushq.delete();
    issq.delete();
    hold = 1'b0;
    step();
    done_req++;
    bad = 1'b0;
    repeat (8) begin
      step();
      if (out_valid || busy || core_start) bad = 1'b1;
    end
    chk("rw_no_output", bad, 0);

    // Random traffic against the model
    rand_lat = 1'b1;
    base = n_res;
    k = 0;
    begin
      int sent, cyc;
      sent = n_push;
      cyc = 0;
      while (n_push - sent < 40 && cyc < 3000) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) != 0) begin
          in_valid = 1'b1;
          in_m = 8'($urandom);
          in_q = 8'($urandom);
          if (in_ready) begin
            pushq.push_back('{m: in_m, q: in_q});
            n_push++;
          end
        end else begin
          in_valid = 1'b0;
        end
        step();
        cyc++;
      end
      in_valid = 1'b0;
      chk("rand_sent", n_push - sent, 40);
    end
    out_ready = 1'b1;
    wait_drain("rand_drain", 500);
    step();
    chk("rand_count", n_res - base, 40);
    chk("rand_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
